// File: rtl/dpwm_duty_capture.sv
// Recovers duty (high time) and rise-to-rise period of an incoming PWM in clk cycles,
// and flags a stuck-high / stuck-low waveform after TIMEOUT clocks without a rising edge.
//
// state | meaning
// IDLE  | capture disabled, outputs hold
// ARM   | waiting for the first rise, nothing published on it
// HIGH  | pwm high, counting high time and period
// LOW   | pwm low, counting period; next rise publishes
// STUCK | fault published, waiting for a rise to restart
module dpwm_duty_capture #(
   parameter int CNT_W   = 9,
   parameter int PER_W   = 11,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] d_meas,
   output logic [PER_W-1:0] period_meas,
   output logic             meas_valid,
   output logic             stuck
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_HIGH, S_LOW, S_STUCK} state_t;

   localparam logic [CNT_W-1:0] HI_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] HI_MAX  = '1;
   localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
   localparam logic [PER_W-1:0] PER_MAX = '1;
   localparam logic [PER_W-1:0] PER_TO  = PER_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] d_meas_q, d_meas_d;
   logic [PER_W-1:0] period_meas_q, period_meas_d;
   logic             meas_valid_q, meas_valid_d;
   logic             stuck_q, stuck_d;

   logic             rise, fall, timeout;
   logic [CNT_W-1:0] hi_inc;
   logic [PER_W-1:0] per_inc;

   assign rise    = s2_q & ~s3_q;
   assign fall    = ~s2_q & s3_q;
   assign timeout = (per_cnt_q == PER_TO);
   assign hi_inc  = (hi_cnt_q == HI_MAX) ? hi_cnt_q : hi_cnt_q + HI_ONE;
   assign per_inc = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_ONE;

   always_comb begin
      state_d       = state_q;
      hi_cnt_d      = hi_cnt_q;
      per_cnt_d     = per_cnt_q;
      d_meas_d      = d_meas_q;
      period_meas_d = period_meas_q;
      meas_valid_d  = 1'b0;
      stuck_d       = stuck_q;

      if (!en) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d   = S_ARM;
               per_cnt_d = '0;
            end
            S_ARM: begin
               if (rise) begin
                  state_d   = S_HIGH;
                  hi_cnt_d  = HI_ONE;
                  per_cnt_d = PER_ONE;
               end else if (timeout) begin
                  state_d       = S_STUCK;
                  meas_valid_d  = 1'b1;
                  stuck_d       = 1'b1;
                  period_meas_d = '0;
                  d_meas_d      = s2_q ? HI_MAX : '0;
               end else begin
                  per_cnt_d = per_inc;
               end
            end
            // Timeout beats a coincident fall; a rise cannot occur while high.
            S_HIGH: begin
               if (timeout) begin
                  state_d       = S_STUCK;
                  meas_valid_d  = 1'b1;
                  stuck_d       = 1'b1;
                  period_meas_d = '0;
                  d_meas_d      = s2_q ? HI_MAX : '0;
               end else begin
                  per_cnt_d = per_inc;
                  if (fall) begin
                     state_d = S_LOW;
                  end else if (s2_q) begin
                     hi_cnt_d = hi_inc;
                  end
               end
            end
            S_LOW: begin
               if (rise) begin
                  state_d       = S_HIGH;
                  meas_valid_d  = 1'b1;
                  stuck_d       = 1'b0;
                  d_meas_d      = hi_cnt_q;
                  period_meas_d = per_cnt_q;
                  hi_cnt_d      = HI_ONE;
                  per_cnt_d     = PER_ONE;
               end else if (timeout) begin
                  state_d       = S_STUCK;
                  meas_valid_d  = 1'b1;
                  stuck_d       = 1'b1;
                  period_meas_d = '0;
                  d_meas_d      = s2_q ? HI_MAX : '0;
               end else begin
                  per_cnt_d = per_inc;
               end
            end
            S_STUCK: begin
               if (rise) begin
                  state_d   = S_HIGH;
                  hi_cnt_d  = HI_ONE;
                  per_cnt_d = PER_ONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         hi_cnt_q      <= '0;
         per_cnt_q     <= '0;
         d_meas_q      <= '0;
         period_meas_q <= '0;
         meas_valid_q  <= 1'b0;
         stuck_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         s1_q          <= pwm_in;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         hi_cnt_q      <= hi_cnt_d;
         per_cnt_q     <= per_cnt_d;
         d_meas_q      <= d_meas_d;
         period_meas_q <= period_meas_d;
         meas_valid_q  <= meas_valid_d;
         stuck_q       <= stuck_d;
      end
   end

   assign d_meas      = d_meas_q;
   assign period_meas = period_meas_q;
   assign meas_valid  = meas_valid_q;
   assign stuck       = stuck_q;

endmodule

// File: tb/tb_dpwm_duty_capture.sv
// Bench for dpwm_duty_capture: DPWM-style and random waveforms checked every cycle against a
// timestamp-based model of edge-to-edge measurement with a fixed two-clock detection delay.
module tb_dpwm_duty_capture;
   localparam int CNT_W   = 9;
   localparam int PER_W   = 11;
   localparam int TIMEOUT = 1023;
   localparam int HI_SAT  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, en, pwm_in;
   logic [CNT_W-1:0] d_meas;
   logic [PER_W-1:0] period_meas;
   logic             meas_valid, stuck;

   int errs   = 0;
   int checks = 0;

   dpwm_duty_capture #(.CNT_W(CNT_W), .PER_W(PER_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
      .d_meas(d_meas), .period_meas(period_meas), .meas_valid(meas_valid), .stuck(stuck)
   );

   always #5 clk = ~clk;

   // Model: mode 0 off, 1 waiting for first rise, 2 measuring, 3 faulted
   int j, mode, t_arm, t_rise, hi_len;
   bit hi_phase;
   bit pa, pb, pc, pd;
   int e_d, e_per;
   bit e_valid, e_stuck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mode = 0; hi_len = 0; hi_phase = 0;
      pa = 0; pb = 0; pc = 0; pd = 0;
      e_d = 0; e_per = 0; e_valid = 0; e_stuck = 0;
   endtask

   task automatic publish_fault(input bit lvl);
      e_valid = 1; e_stuck = 1; e_per = 0;
      e_d = lvl ? HI_SAT : 0;
      mode = 3;
   endtask

   task automatic start_meas();
      mode = 2; t_rise = j; hi_len = 1; hi_phase = 1;
   endtask

   // Decision at edge j sees the pwm level sampled two edges earlier.
   task automatic model_edge(input bit ev);
      bit lvl, prv, rise_e;
      lvl = pc; prv = pd;
      rise_e = lvl && !prv;
      e_valid = 0;
      if (!ev) begin
         mode = 0;
      end else begin
         case (mode)
            0: begin mode = 1; t_arm = j; end
            1: begin
               if (rise_e) start_meas();
               else if (j - t_arm - 1 == TIMEOUT) publish_fault(lvl);
            end
            2: begin
               if (rise_e) begin
                  e_valid = 1; e_stuck = 0;
                  e_d = (hi_len > HI_SAT) ? HI_SAT : hi_len;
                  e_per = j - t_rise;
                  start_meas();
               end else if (j - t_rise == TIMEOUT) begin
                  publish_fault(lvl);
               end else if (hi_phase) begin
                  if (lvl) hi_len++;
                  else hi_phase = 0;
               end
            end
            default: if (rise_e) start_meas();
         endcase
      end
   endtask

   task automatic tick(input bit pv, input bit ev);
      pwm_in = pv; en = ev;
      @(posedge clk);
      j++;
      pd = pc; pc = pb; pb = pa; pa = pv;
      model_edge(ev);
      @(negedge clk);
      chk("meas_valid", 32'(meas_valid), 32'(e_valid));
      chk("d_meas", 32'(d_meas), 32'(e_d));
      chk("period_meas", 32'(period_meas), 32'(e_per));
      chk("stuck", 32'(stuck), 32'(e_stuck));
   endtask

   task automatic dpwm(input int d, input int n);
      for (int p = 0; p < n; p++)
         for (int i = 0; i < 512; i++) tick(i < d, 1'b1);
   endtask

   task automatic wave(input int hi, input int lo);
      for (int i = 0; i < hi; i++) tick(1'b1, 1'b1);
      for (int i = 0; i < lo; i++) tick(1'b0, 1'b1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_d"}, 32'(d_meas), 0);
      chk({tag, "_per"}, 32'(period_meas), 0);
      chk({tag, "_valid"}, 32'(meas_valid), 0);
      chk({tag, "_stuck"}, 32'(stuck), 0);
   endtask

   initial begin
      j = 0;
      rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // basic d=100, then command steps at period boundaries
      dpwm(100, 3);
      dpwm(511, 2);
      dpwm(1, 2);

      // stuck low from enable, then recovery at d=200
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      for (int i = 0; i < TIMEOUT + 10; i++) tick(1'b0, 1'b1);
      dpwm(200, 3);

      // running at d=300, then stuck high
      dpwm(300, 3);
      for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1);
      dpwm(300, 2);

      // enable dropped for 50 clocks mid-high
      dpwm(300, 2);
      for (int i = 0; i < 512; i++) tick(i < 300, !(i >= 50 && i < 100));
      dpwm(300, 3);

      // random duty commands and free-form waveforms including single-clock glitches
      for (int k = 0; k < 6; k++) dpwm(int'($urandom_range(511, 1)), 2);
      wave(1, 300);
      wave(1, 300);
      for (int k = 0; k < 8; k++) wave(int'($urandom_range(300, 1)), int'($urandom_range(400, 1)));
      wave(50, 1010);

      // async reset mid-low, then a fresh run
      dpwm(100, 2);
      for (int i = 0; i < 400; i++) tick(i < 100, 1'b1);
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero("rst_hold");
      rst = 1'b0;
      dpwm(100, 3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
